// File: rtl/red_pitaya_lock_supervisor.sv
// Lock acquisition/supervision FSM beside one PID: triangle sweep, seed
// integrators on threshold crossing, hold on dropouts, re-sweep on loss.
//
// Ports:
//   clk_i, rstn_i            clock, async active-low reset
//   enable_i                 supervisor enable (0 forces IDLE)
//   pid_dat_i, mon_dat_i     PID output and lock-monitor samples
//   set_*                    threshold, delays, rails, sweep range/step
//   railed_o, hold_o,        PID control: rail flags, integrator hold,
//   int_rst_o,               integrator reset,
//   int_ctr_rst_o/_val_o     integrator preload strobe and value
//   sweep_o, sweep_en_o      sweep value and actuator mux select
//   locked_o, state_o        lock flag, FSM state
//   relock_cnt_o             saturating count of LOCKED->SWEEP events
module red_pitaya_lock_supervisor #(
   parameter int CNT_BITS    = 24,
   parameter int RELOCK_BITS = 16
)(
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          enable_i,
   input  logic signed [13:0]            pid_dat_i,
   input  logic signed [13:0]            mon_dat_i,
   input  logic signed [13:0]            set_lock_thr_i,
   input  logic        [CNT_BITS-1:0]    set_lock_dly_i,
   input  logic        [CNT_BITS-1:0]    set_unlock_dly_i,
   input  logic signed [13:0]            set_rail_lo_i,
   input  logic signed [13:0]            set_rail_hi_i,
   input  logic signed [13:0]            set_sweep_min_i,
   input  logic signed [13:0]            set_sweep_max_i,
   input  logic        [12:0]            set_sweep_step_i,
   output logic        [1:0]             railed_o,
   output logic                          hold_o,
   output logic                          int_rst_o,
   output logic                          int_ctr_rst_o,
   output logic signed [13:0]            int_ctr_val_o,
   output logic signed [13:0]            sweep_o,
   output logic                          sweep_en_o,
   output logic                          locked_o,
   output logic        [1:0]             state_o,
   output logic        [RELOCK_BITS-1:0] relock_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_ACQ   = 2'd2,
      S_LOCK  = 2'd3
   } state_t;

   state_t               state;
   logic                 up;
   logic [CNT_BITS-1:0]  cnt;
   logic                 in_lock;
   logic signed [14:0]   ext_sw;
   logic signed [14:0]   ext_min;
   logic signed [14:0]   ext_max;
   logic signed [14:0]   n_up;
   logic signed [14:0]   n_dn;
   logic signed [13:0]   sweep_nxt;
   logic                 up_nxt;

   assign in_lock = (mon_dat_i >= set_lock_thr_i);
   assign state_o = state;

   // Next sweep point in 15 bits so the step can never wrap.
   // Reaching a limit reverses direction, so each turning point
   // is emitted exactly once.
   always_comb begin
      ext_sw    = {sweep_o[13], sweep_o};
      ext_min   = {set_sweep_min_i[13], set_sweep_min_i};
      ext_max   = {set_sweep_max_i[13], set_sweep_max_i};
      n_up      = ext_sw + $signed({2'b00, set_sweep_step_i});
      n_dn      = ext_sw - $signed({2'b00, set_sweep_step_i});
      sweep_nxt = sweep_o;
      up_nxt    = up;
      if (ext_min > ext_max) begin
         sweep_nxt = set_sweep_min_i;
      end else if (up) begin
         if (n_up >= ext_max) begin
            sweep_nxt = set_sweep_max_i;
            up_nxt    = 1'b0;
         end else begin
            sweep_nxt = n_up[13:0];
         end
      end else begin
         if (n_dn <= ext_min) begin
            sweep_nxt = set_sweep_min_i;
            up_nxt    = 1'b1;
         end else begin
            sweep_nxt = n_dn[13:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state         <= S_IDLE;
         up            <= 1'b1;
         cnt           <= '0;
         railed_o      <= 2'b00;
         hold_o        <= 1'b0;
         int_rst_o     <= 1'b1;
         int_ctr_rst_o <= 1'b0;
         int_ctr_val_o <= '0;
         sweep_o       <= '0;
         sweep_en_o    <= 1'b0;
         locked_o      <= 1'b0;
         relock_cnt_o  <= '0;
      end else begin
         railed_o      <= {pid_dat_i >= set_rail_hi_i,
                           pid_dat_i <= set_rail_lo_i};
         int_ctr_rst_o <= 1'b0;
         if (!enable_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            int_rst_o  <= 1'b1;
            sweep_en_o <= 1'b0;
            hold_o     <= 1'b0;
            locked_o   <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  state      <= S_SWEEP;
                  cnt        <= '0;
                  sweep_o    <= set_sweep_min_i;
                  up         <= 1'b1;
                  sweep_en_o <= 1'b1;
                  int_rst_o  <= 1'b1;
               end
               S_SWEEP: begin
                  if (in_lock) begin
                     // seed integrator with the point that crossed
                     state         <= S_ACQ;
                     cnt           <= '0;
                     int_ctr_val_o <= sweep_o;
                     int_ctr_rst_o <= 1'b1;
                     sweep_en_o    <= 1'b0;
                     int_rst_o     <= 1'b0;
                  end else begin
                     sweep_o <= sweep_nxt;
                     up      <= up_nxt;
                  end
               end
               S_ACQ: begin
                  if (!in_lock) begin
                     state      <= S_SWEEP;
                     cnt        <= '0;
                     sweep_en_o <= 1'b1;
                     int_rst_o  <= 1'b1;
                  end else if (cnt >= set_lock_dly_i) begin
                     state    <= S_LOCK;
                     cnt      <= '0;
                     locked_o <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_LOCK: begin
                  if (in_lock) begin
                     cnt    <= '0;
                     hold_o <= 1'b0;
                  end else if (cnt >= set_unlock_dly_i) begin
                     state      <= S_SWEEP;
                     cnt        <= '0;
                     up         <= 1'b1;
                     locked_o   <= 1'b0;
                     hold_o     <= 1'b0;
                     sweep_en_o <= 1'b1;
                     int_rst_o  <= 1'b1;
                     if (relock_cnt_o != '1)
                        relock_cnt_o <= relock_cnt_o + 1'b1;
                  end else begin
                     // short dropout: freeze integrators
                     cnt    <= cnt + 1'b1;
                     hold_o <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
